// File: rtl/conv_tile_scheduler.sv
// Layer sequencer: walks output-channel groups and spatial tiles, handshaking the
// buffer load, one PE pass, partial-sum drain and writeback for every tile.
module conv_tile_scheduler #(
  parameter int TILE_W_BITS = 4,
  parameter int PE_TIMEOUT  = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [1:0]             cfg_ci,
  input  logic [1:0]             cfg_co,
  input  logic [TILE_W_BITS-1:0] cfg_tiles_x,
  input  logic [TILE_W_BITS-1:0] cfg_tiles_y,
  output logic                   pe_start_conv,
  output logic                   pe_start_again,
  input  logic                   pe_last_ch,
  output logic                   load_req,
  input  logic                   load_done,
  output logic                   wb_req,
  input  logic                   wb_done,
  output logic [TILE_W_BITS-1:0] tile_x,
  output logic [TILE_W_BITS-1:0] tile_y,
  output logic [1:0]             co_grp,
  output logic                   busy,
  output logic                   layer_done,
  output logic                   err_timeout
);

  localparam int TMR_W = (PE_TIMEOUT < 2) ? 1 : $clog2(PE_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CFG, LOAD, RUN, WAIT_PE, WB, NEXT, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [1:0]             cfg_ci_reg, cfg_ci_next;
  logic [1:0]             cfg_co_reg, cfg_co_next;
  logic [TILE_W_BITS-1:0] cfg_tx_reg, cfg_tx_next;
  logic [TILE_W_BITS-1:0] cfg_ty_reg, cfg_ty_next;
  logic [TILE_W_BITS-1:0] tile_x_reg, tile_x_next;
  logic [TILE_W_BITS-1:0] tile_y_reg, tile_y_next;
  logic [1:0]             co_grp_reg, co_grp_next;
  logic                   err_reg, err_next;
  logic [TMR_W-1:0]       timer_reg, timer_next;
  logic                   pe_last_prev_reg;
  logic                   conv_reg, again_reg, load_req_reg, wb_req_reg, busy_reg, done_reg;
  logic                   pe_fall, timeout_hit, last_tile;
  logic                   unused_cfg_ci;

  // cfg_ci only travels with the layer for observation; nothing here consumes it.
  assign unused_cfg_ci = ^cfg_ci_reg;

  assign pe_fall     = pe_last_prev_reg && !pe_last_ch;
  // timer_reg counts cycles since the RUN strobe, so the error lands PE_TIMEOUT cycles after it
  assign timeout_hit = (PE_TIMEOUT != 0) && ((32'(timer_reg) + 32'd1) >= 32'(PE_TIMEOUT));
  assign last_tile   = (co_grp_reg == cfg_co_reg) && (tile_y_reg == cfg_ty_reg) &&
                       (tile_x_reg == cfg_tx_reg);

  always_comb begin
    state_next  = state_reg;
    cfg_ci_next = cfg_ci_reg;
    cfg_co_next = cfg_co_reg;
    cfg_tx_next = cfg_tx_reg;
    cfg_ty_next = cfg_ty_reg;
    tile_x_next = tile_x_reg;
    tile_y_next = tile_y_reg;
    co_grp_next = co_grp_reg;
    err_next    = err_reg;
    timer_next  = timer_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_next  = CFG;
            cfg_ci_next = cfg_ci;
            cfg_co_next = cfg_co;
            cfg_tx_next = cfg_tiles_x;
            cfg_ty_next = cfg_tiles_y;
            tile_x_next = '0;
            tile_y_next = '0;
            co_grp_next = '0;
            err_next    = 1'b0;
          end
        end
        CFG:  state_next = LOAD;
        LOAD: if (load_done) state_next = RUN;
        RUN: begin
          timer_next = TMR_W'(1);
          state_next = WAIT_PE;
        end
        WAIT_PE: begin
          timer_next = timer_reg + TMR_W'(1);
          if (pe_fall) begin
            state_next = WB;
          end else if (timeout_hit) begin
            state_next = DONE;
            err_next   = 1'b1;
          end
        end
        WB: if (wb_done) state_next = NEXT;
        NEXT: begin
          if (last_tile) begin
            state_next = DONE;
          end else begin
            state_next = LOAD;
            if (tile_x_reg == cfg_tx_reg) begin
              tile_x_next = '0;
              if (tile_y_reg == cfg_ty_reg) begin
                tile_y_next = '0;
                co_grp_next = co_grp_reg + 2'd1;
              end else begin
                tile_y_next = tile_y_reg + TILE_W_BITS'(1);
              end
            end else begin
              tile_x_next = tile_x_reg + TILE_W_BITS'(1);
            end
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output flags are decoded from the next state so every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      cfg_ci_reg       <= '0;
      cfg_co_reg       <= '0;
      cfg_tx_reg       <= '0;
      cfg_ty_reg       <= '0;
      tile_x_reg       <= '0;
      tile_y_reg       <= '0;
      co_grp_reg       <= '0;
      err_reg          <= 1'b0;
      timer_reg        <= '0;
      pe_last_prev_reg <= 1'b0;
      conv_reg         <= 1'b0;
      again_reg        <= 1'b0;
      load_req_reg     <= 1'b0;
      wb_req_reg       <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cfg_ci_reg       <= cfg_ci_next;
      cfg_co_reg       <= cfg_co_next;
      cfg_tx_reg       <= cfg_tx_next;
      cfg_ty_reg       <= cfg_ty_next;
      tile_x_reg       <= tile_x_next;
      tile_y_reg       <= tile_y_next;
      co_grp_reg       <= co_grp_next;
      err_reg          <= err_next;
      timer_reg        <= timer_next;
      pe_last_prev_reg <= pe_last_ch;
      conv_reg         <= (state_next == CFG);
      again_reg        <= (state_next == RUN);
      load_req_reg     <= (state_next == LOAD);
      wb_req_reg       <= (state_next == WB);
      busy_reg         <= (state_next != IDLE);
      done_reg         <= (state_next == DONE);
    end
  end

  assign pe_start_conv  = conv_reg;
  assign pe_start_again = again_reg;
  assign load_req       = load_req_reg;
  assign wb_req         = wb_req_reg;
  assign tile_x         = tile_x_reg;
  assign tile_y         = tile_y_reg;
  assign co_grp         = co_grp_reg;
  assign busy           = busy_reg;
  assign layer_done     = done_reg;
  assign err_timeout    = err_reg;

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Bench for conv_tile_scheduler: each layer is expanded into a per-cycle script of
// inputs and expected outputs from phase lengths, then replayed and compared.
module tb_conv_tile_scheduler;

  localparam int PE_TO = 50;

  typedef struct packed {
    logic       start, abort, rst, load_done, pe_last_ch, wb_done;
    logic [1:0] cfg_ci, cfg_co;
    logic [3:0] cfg_tx, cfg_ty;
  } in_t;

  typedef struct packed {
    logic       conv, again, lreq, wreq;
    logic [3:0] tx, ty;
    logic [1:0] co;
    logic       busy, done, err;
  } out_t;

  logic       clk = 1'b0;
  logic       rst, start, abort, pe_last_ch, load_done, wb_done;
  logic [1:0] cfg_ci, cfg_co;
  logic [3:0] cfg_tiles_x, cfg_tiles_y;
  logic       pe_start_conv, pe_start_again, load_req, wb_req, busy, layer_done, err_timeout;
  logic [3:0] tile_x, tile_y;
  logic [1:0] co_grp;

  always #5 clk = ~clk;

  conv_tile_scheduler #(.TILE_W_BITS(4), .PE_TIMEOUT(PE_TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_ci(cfg_ci), .cfg_co(cfg_co), .cfg_tiles_x(cfg_tiles_x), .cfg_tiles_y(cfg_tiles_y),
    .pe_start_conv(pe_start_conv), .pe_start_again(pe_start_again), .pe_last_ch(pe_last_ch),
    .load_req(load_req), .load_done(load_done), .wb_req(wb_req), .wb_done(wb_done),
    .tile_x(tile_x), .tile_y(tile_y), .co_grp(co_grp), .busy(busy),
    .layer_done(layer_done), .err_timeout(err_timeout)
  );

  in_t        in_q[$];
  out_t       exp_q[$];
  logic [9:0] seq_q[$];
  logic [3:0] m_tx = '0, m_ty = '0;
  logic [1:0] m_co = '0;
  logic       m_err = 1'b0;
  int  kill_ph = -1, kill_nth = 0, kill_cnt = 0;
  bit  kill_rst = 0, killed = 0;
  int  fix_dl = 0, fix_h = 0, fix_dw = 0;
  int  errors = 0, checks = 0, cyc = 0;
  int  n_conv, n_again, n_done, t_again, t_err;
  logic prev_err = 1'b0;

  function automatic out_t mk(input bit cv, input bit ag, input bit lr, input bit wr,
                              input bit bz, input bit dn);
    out_t o;
    o.conv = cv; o.again = ag; o.lreq = lr; o.wreq = wr;
    o.tx = m_tx; o.ty = m_ty; o.co = m_co;
    o.busy = bz; o.done = dn; o.err = m_err;
    return o;
  endfunction

  function automatic in_t rnd_in();
    in_t v;
    v.start      = ($urandom_range(0, 3) == 0);
    v.abort      = 1'b0;
    v.rst        = 1'b0;
    v.load_done  = ($urandom_range(0, 3) == 0);
    v.wb_done    = ($urandom_range(0, 3) == 0);
    v.pe_last_ch = ($urandom_range(0, 1) == 1);
    v.cfg_ci     = 2'($urandom_range(0, 3));
    v.cfg_co     = 2'($urandom_range(0, 3));
    v.cfg_tx     = 4'($urandom_range(0, 15));
    v.cfg_ty     = 4'($urandom_range(0, 15));
    return v;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("conv=%b again=%b load_req=%b wb_req=%b x=%0d y=%0d co=%0d busy=%b done=%b err=%b",
                     o.conv, o.again, o.lreq, o.wreq, o.tx, o.ty, o.co, o.busy, o.done, o.err);
  endfunction

  task automatic push(input in_t iv, input out_t ov, input int ph);
    if (!killed && ph == kill_ph) begin
      kill_cnt++;
      if (kill_cnt == kill_nth) begin
        killed = 1;
        if (kill_rst) iv.rst = 1'b1;
        else iv.abort = 1'b1;
      end
    end
    in_q.push_back(iv);
    exp_q.push_back(ov);
  endtask

  function automatic in_t idle_in();
    in_t v;
    v = rnd_in();
    v.start = 1'b0;
    return v;
  endfunction

  // Phase ids: 1 start, 2 CFG, 3 LOAD, 4 RUN, 5 WAIT_PE, 6 WB, 7 NEXT, 8 DONE
  task automatic gen_body(input logic [1:0] co, input logic [3:0] tx, input logic [3:0] ty,
                          input int to_pass);
    in_t iv;
    int  dl, dw, a, h, pass;
    bit  pre;
    iv = rnd_in();
    iv.start = 1'b1; iv.cfg_co = co; iv.cfg_tx = tx; iv.cfg_ty = ty;
    push(iv, mk(0, 0, 0, 0, 0, 0), 1);
    if (killed) return;
    m_tx = '0; m_ty = '0; m_co = '0; m_err = 1'b0;
    push(rnd_in(), mk(1, 0, 0, 0, 1, 0), 2);
    if (killed) return;
    pass = 0;
    forever begin
      dl = (fix_dl != 0) ? fix_dl : $urandom_range(1, 4);
      for (int i = 1; i <= dl; i++) begin
        iv = rnd_in(); iv.load_done = (i == dl);
        push(iv, mk(0, 0, 1, 0, 1, 0), 3);
        if (killed) return;
      end
      pre = (pass != to_pass) && (fix_h == 0) && ($urandom_range(0, 2) == 0);
      iv = rnd_in(); iv.pe_last_ch = pre;
      push(iv, mk(0, 1, 0, 0, 1, 0), 4);
      if (killed) return;
      if (pass == to_pass) begin
        for (int k = 1; k < PE_TO; k++) begin
          iv = rnd_in(); iv.pe_last_ch = 1'b0;
          push(iv, mk(0, 0, 0, 0, 1, 0), 5);
          if (killed) return;
        end
        m_err = 1'b1;
        push(rnd_in(), mk(0, 0, 0, 0, 1, 1), 8);
        return;
      end
      a = pre ? 0 : $urandom_range(0, 3);
      h = (fix_h != 0) ? fix_h : (pre ? $urandom_range(0, 16) : $urandom_range(1, 16));
      for (int k = 0; k < a + h + 1; k++) begin
        iv = rnd_in(); iv.pe_last_ch = (k >= a) && (k < a + h);
        push(iv, mk(0, 0, 0, 0, 1, 0), 5);
        if (killed) return;
      end
      dw = (fix_dw != 0) ? fix_dw : $urandom_range(1, 4);
      for (int i = 1; i <= dw; i++) begin
        iv = rnd_in(); iv.wb_done = (i == dw);
        push(iv, mk(0, 0, 0, 1, 1, 0), 6);
        if (killed) return;
      end
      push(rnd_in(), mk(0, 0, 0, 0, 1, 0), 7);
      if (killed) return;
      if (m_co == co && m_ty == ty && m_tx == tx) begin
        push(rnd_in(), mk(0, 0, 0, 0, 1, 1), 8);
        return;
      end
      if (m_tx == tx) begin
        m_tx = '0;
        if (m_ty == ty) begin m_ty = '0; m_co = m_co + 2'd1; end
        else m_ty = m_ty + 4'd1;
      end else begin
        m_tx = m_tx + 4'd1;
      end
      pass++;
    end
  endtask

  task automatic layer(input int co, input int tx, input int ty, input int to_pass,
                       input int kph, input int knth, input bit krst);
    kill_ph = kph; kill_nth = knth; kill_rst = krst; kill_cnt = 0; killed = 0;
    gen_body(2'(co), 4'(tx), 4'(ty), to_pass);
    if (killed) begin
      if (kill_rst) begin m_tx = '0; m_ty = '0; m_co = '0; m_err = 1'b0; end
      push(idle_in(), mk(0, 0, 0, 0, 0, 0), 0);
    end
    for (int i = 0; i < 3; i++) push(idle_in(), mk(0, 0, 0, 0, 0, 0), 0);
  endtask

  task automatic run_trace();
    out_t act;
    for (int i = 0; i < in_q.size(); i++) begin
      @(negedge clk);
      act = {pe_start_conv, pe_start_again, load_req, wb_req, tile_x, tile_y, co_grp,
             busy, layer_done, err_timeout};
      checks++;
      if (act !== exp_q[i]) begin
        errors++;
        if (errors <= 30)
          $display("FAIL outputs cycle %0d: actual %s / required %s", cyc, fmt(act), fmt(exp_q[i]));
      end
      if (act.conv === 1'b1) n_conv++;
      if (act.again === 1'b1) begin
        n_again++;
        t_again = cyc;
        seq_q.push_back({act.co, act.ty, act.tx});
      end
      if (act.done === 1'b1) n_done++;
      if (act.err === 1'b1 && prev_err !== 1'b1) t_err = cyc;
      prev_err = act.err;
      cyc++;
      rst = in_q[i].rst; start = in_q[i].start; abort = in_q[i].abort;
      load_done = in_q[i].load_done; wb_done = in_q[i].wb_done; pe_last_ch = in_q[i].pe_last_ch;
      cfg_ci = in_q[i].cfg_ci; cfg_co = in_q[i].cfg_co;
      cfg_tiles_x = in_q[i].cfg_tx; cfg_tiles_y = in_q[i].cfg_ty;
    end
    in_q.delete();
    exp_q.delete();
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic clr_ev();
    n_conv = 0; n_again = 0; n_done = 0; t_again = -1; t_err = -1;
    seq_q.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; pe_last_ch = 1'b0; load_done = 1'b0; wb_done = 1'b0;
    cfg_ci = '0; cfg_co = '0; cfg_tiles_x = '0; cfg_tiles_y = '0;
    repeat (3) @(posedge clk);

    // single tile with fixed handshake delays
    fix_dl = 3; fix_h = 16; fix_dw = 2;
    clr_ev(); layer(0, 0, 0, -1, -1, 1, 0); run_trace();
    chk("single_conv_strobes", n_conv, 1);
    chk("single_passes", n_again, 1);
    chk("single_layer_done", n_done, 1);
    fix_dl = 0; fix_h = 0; fix_dw = 0;

    // 2 channel groups x 2 rows x 3 columns, row-major with group outermost
    clr_ev(); layer(1, 2, 1, -1, -1, 1, 0); run_trace();
    chk("multi_passes", n_again, 12);
    chk("multi_layer_done", n_done, 1);
    if (seq_q.size() == 12) begin
      chk("multi_seq_0", int'(seq_q[0]), 'h000);
      chk("multi_seq_2", int'(seq_q[2]), 'h002);
      chk("multi_seq_3", int'(seq_q[3]), 'h010);
      chk("multi_seq_6", int'(seq_q[6]), 'h100);
      chk("multi_seq_11", int'(seq_q[11]), 'h112);
    end

    // second tile never drains: timeout ends the layer
    clr_ev(); layer(0, 1, 0, 1, -1, 1, 0); run_trace();
    chk("timeout_latency", t_err - t_again, PE_TO);
    chk("timeout_layer_done", n_done, 1);
    clr_ev(); layer(0, 0, 0, -1, -1, 1, 0); run_trace();
    chk("after_timeout_done", n_done, 1);

    // abort during the second writeback cycle
    clr_ev(); layer(1, 1, 1, -1, 6, 2, 0); run_trace();
    chk("abort_no_layer_done", n_done, 0);

    // reset during WAIT_PE, then a clean layer
    clr_ev(); layer(0, 1, 1, -1, 5, 3, 1); run_trace();
    chk("reset_no_layer_done", n_done, 0);
    clr_ev(); layer(0, 1, 1, -1, -1, 1, 0); run_trace();
    chk("post_reset_passes", n_again, 4);
    chk("post_reset_done", n_done, 1);

    // counter boundaries: full column range, full row range, top channel group
    clr_ev(); layer(0, 15, 0, -1, -1, 1, 0); run_trace();
    chk("wide_x_passes", n_again, 16);
    clr_ev(); layer(0, 0, 15, -1, -1, 1, 0); run_trace();
    chk("tall_y_passes", n_again, 16);
    clr_ev(); layer(3, 1, 1, -1, -1, 1, 0); run_trace();
    chk("max_co_passes", n_again, 16);

    for (int r = 0; r < 25; r++) begin
      int kp;
      int tp;
      kp = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : -1;
      tp = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 2) : -1;
      layer($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2), tp,
            kp, $urandom_range(1, 3), $urandom_range(0, 1) == 1);
      run_trace();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_tile_scheduler.md
Name: conv_tile_scheduler

Overview:
Layer-level sequencer that drives the PE array controller through a full convolution layer.
- Latches the layer configuration and issues the one-shot configuration strobe.
- For every output-channel group and spatial tile: requests the IFM/weight buffer load, fires one PE pass, waits for the last-channel partial sums to drain, then hands the tile to output writeback.
- Sits between the top-level host/control registers and the PE FSM, IFM/WGT buffer loaders and output writeback unit.

Parameters:
TILE_W_BITS, 4, width of tile column/row counters (max 16 tiles per axis)
PE_TIMEOUT, 1023, max cycles in RUN before error; 0 disables the check

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
start  in  1  layer start pulse; accepted only in IDLE
abort  in  1  soft abort; returns to IDLE next cycle from any state
cfg_ci  in  2  input-channel groups minus 1 (8 channels per group)
cfg_co  in  2  output-channel groups minus 1
cfg_tiles_x  in  TILE_W_BITS  tile columns minus 1
cfg_tiles_y  in  TILE_W_BITS  tile rows minus 1
pe_start_conv  out  1  one-cycle configuration strobe to PE FSM
pe_start_again  out  1  one-cycle tile-pass strobe to PE FSM
pe_last_ch  in  1  PE last-channel valid (delayed, multi-cycle high)
load_req  out  1  buffer load request, level
load_done  in  1  loader completion pulse
wb_req  out  1  writeback request, level
wb_done  in  1  writeback completion pulse
tile_x  out  TILE_W_BITS  current tile column
tile_y  out  TILE_W_BITS  current tile row
co_grp  out  2  current output-channel group
busy  out  1  high in any state except IDLE
layer_done  out  1  one-cycle pulse at layer completion
err_timeout  out  1  sticky; cleared by rst or next accepted start

Behaviour:
- All outputs are registered. Reset values: every output 0; state IDLE; config registers 0.
- States: IDLE, CFG, LOAD, RUN, WAIT_PE, WB, NEXT, DONE.
- IDLE:
  - start=1: latch cfg_*, clear counters and err_timeout, go to CFG.
  - start while busy is ignored.
- CFG: pe_start_conv=1 for exactly this cycle; go to LOAD.
- LOAD:
  - load_req=1 until load_done is sampled high; load_req is low the cycle after.
  - load_done with load_req low is ignored.
  - On load_done go to RUN.
- RUN: pe_start_again=1 for one cycle; go to WAIT_PE.
- WAIT_PE:
  - Wait for the falling edge of pe_last_ch (registered previous value 1, current 0). That edge is tile compute complete; go to WB.
  - pe_last_ch already high on entry is fine; only the falling edge counts.
  - Timeout counter runs from the RUN cycle. If it reaches PE_TIMEOUT: set err_timeout and go to DONE; layer_done still pulses.
- WB: wb_req=1 until wb_done is sampled; go to NEXT.
- NEXT: advance counters, row-major, channel-group outermost.
  - tile_x increments.
  - At cfg_tiles_x, tile_x wraps to 0 and tile_y increments.
  - At cfg_tiles_y, tile_y wraps and co_grp increments.
  - If co_grp==cfg_co and both tile counters are at max, go to DONE; else go to LOAD.
- DONE: layer_done=1 for one cycle; go to IDLE; counters hold final values.
- abort:
  - Has priority over all transitions.
  - Next cycle: state IDLE; load_req, wb_req and strobes 0; no layer_done.
  - Counters hold their values; err_timeout unaffected.
- rst mid-operation: all state and outputs return to reset values on the next edge.
- Total PE passes per layer = (cfg_co+1)*(cfg_tiles_x+1)*(cfg_tiles_y+1). cfg_ci is latched and forwarded for observation only.
- Minimum per-tile overhead outside the PE/loader/writeback waits: 4 cycles (LOAD, RUN, WB, NEXT).

Test Plan:
- cfg_co=0, tiles_x=0, tiles_y=0; load_done 3 cycles after load_req; pe_last_ch high for 16 cycles; wb_done after 2 cycles -> exactly one pe_start_conv, one pe_start_again, one layer_done; busy low the cycle after layer_done.
- cfg_co=1, tiles_x=2, tiles_y=1 -> 12 pe_start_again pulses; (co_grp,tile_y,tile_x) sequence 0,0,0 / 0,0,1 / 0,0,2 / 0,1,0 … 1,1,2; one layer_done.
- load_done asserted 1 cycle after load_req and again while idle in WAIT_PE -> the stray pulse is ignored; each load_req deasserts the cycle after its accepted load_done.
- PE_TIMEOUT=50, pe_last_ch held low -> err_timeout set 50 cycles after pe_start_again, layer_done pulses, state IDLE; next start clears err_timeout.
- abort asserted in WB with wb_req high -> next cycle wb_req=0, busy=0, no layer_done; start while busy in another run is ignored.
- rst asserted during WAIT_PE -> next edge all outputs 0, state IDLE; fresh start then runs a full layer normally.
